// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and load/store.
// Data accesses win by default. A streak counter guarantees that a waiting fetch is eventually served.
//   state  | meaning
//   IDLE   | no access outstanding, arbitrate this cycle
//   BUSY_I | fetch access in flight, waiting for mem_ack_i
//   BUSY_D | data access in flight, waiting for mem_ack_i
//   DONE_I | if_done_o pulse, fetched word on if_rdata_o
//   DONE_D | d_done_o pulse, load word on d_rdata_o
//   DROP   | flushed fetch still in flight, result discarded on ack
module unified_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYC     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  localparam int STRK_W  = $clog2(MAX_DATA_STREAK + 2);
  localparam int WD_W    = $clog2(TIMEOUT_CYC + 2);
  localparam int WD_LOAD = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam bit WD_EN   = (TIMEOUT_CYC > 0);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_DATA_STREAK);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSY_I, S_BUSY_D, S_DONE_I, S_DONE_D, S_DROP
  } state_e;

  state_e              state_q;
  logic [STRK_W-1:0]   streak_q;
  logic [WD_W-1:0]     wd_q;
  logic                mem_req_q, mem_we_q, if_done_q, d_done_q, timeout_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, d_rdata_q;
  logic                d_win;

  assign d_win = d_req_i && (!if_req_i || (streak_q < STRK_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if (!if_req_i) streak_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (d_win) begin
            state_q     <= S_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            wd_q        <= WD_W'(WD_LOAD);
            if (if_req_i && (streak_q < STRK_MAX)) streak_q <= streak_q + STRK_W'(1);
          end else if (if_req_i && !if_flush_i) begin
            state_q     <= S_BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            wd_q        <= WD_W'(WD_LOAD);
            streak_q    <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D, S_DROP: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (state_q == S_BUSY_D) begin
              d_rdata_q <= mem_rdata_i;
              d_done_q  <= 1'b1;
              state_q   <= S_DONE_D;
            end else if (state_q == S_BUSY_I && !if_flush_i) begin
              if_rdata_q <= mem_rdata_i;
              if_done_q  <= 1'b1;
              state_q    <= S_DONE_I;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (WD_EN && wd_q == '0) begin
            // abandon the access; the requester is still asserting and gets re-arbitrated
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q - WD_W'(1);
            if (state_q == S_BUSY_I && if_flush_i) state_q <= S_DROP;
          end
        end
        S_DONE_I, S_DONE_D: state_q <= S_IDLE;
        default:            state_q <= S_IDLE;
      endcase
    end
  end

  // a flush landing on the completion cycle still has to hide the stale instruction
  assign if_done_o   = if_done_q & ~if_flush_i;
  assign d_done_o    = d_done_q;
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign d_stall_o   = d_req_i & ~d_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a behavioural memory acks after a programmable latency
// and returns addr+3 on reads, logging every completed access for order checks.
module tb_unified_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0, if_flush_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_done_o, if_stall_o, d_done_o, d_stall_o, mem_req_o, mem_we_o, timeout_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  bit no_ack = 1'b0;
  int cnt = 0;
  int n_log = 0;
  logic [31:0] log_addr [32];
  logic [31:0] log_wdata[32];
  logic        log_we   [32];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // memory model, driven on the falling edge
  always @(negedge clk_i) begin
    if (rst_i) begin
      n_log = 0; cnt = 0; mem_ack_i = 1'b0;
    end else if (mem_ack_i || !mem_req_o || no_ack) begin
      mem_ack_i = 1'b0;
      if (!mem_req_o) cnt = 0;
    end else begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_addr_o + 32'h3;
        if (n_log < 32) begin
          log_addr[n_log] = mem_addr_o; log_wdata[n_log] = mem_wdata_o; log_we[n_log] = mem_we_o;
          n_log++;
        end
        cnt = 0;
      end
    end
  end

  task automatic apply_reset();
    if_req_i = 0; d_req_i = 0; d_we_i = 0; if_flush_i = 0; no_ack = 0; lat = 1;
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; if_req_i = 1; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h20; if_addr_i = 32'h10;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin $display("FAIL reset_mem_req: got %0b want 0", mem_req_o); n_bad++; end
    n_cmp++; if (if_done_o !== 1'b0 || d_done_o !== 1'b0) begin $display("FAIL reset_done: got %0b/%0b want 0/0", if_done_o, d_done_o); n_bad++; end
    n_cmp++; if (timeout_o !== 1'b0) begin $display("FAIL reset_timeout: got %0b want 0", timeout_o); n_bad++; end
    n_cmp++; if (mem_addr_o !== 32'h0 || mem_we_o !== 1'b0) begin $display("FAIL reset_mem_bus: got %h/%0b want 0/0", mem_addr_o, mem_we_o); n_bad++; end
    n_cmp++; if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata_o, d_rdata_o); n_bad++; end
    rst_i = 0;
    @(posedge clk_i); #1;
    n_cmp++; if (mem_req_o !== 1'b1) begin $display("FAIL reset_first_req: got %0b want 1", mem_req_o); n_bad++; end
    n_cmp++; if (mem_addr_o !== 32'h20) begin $display("FAIL reset_first_addr: got %h want 00000020", mem_addr_o); n_bad++; end
    apply_reset();
  endtask

  task automatic test_fetch();
    apply_reset();
    lat = 2; if_addr_i = 32'h10; if_req_i = 1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i); #1;
      n_cmp++; if (if_done_o !== (i == 3)) begin $display("FAIL fetch_done_c%0d: got %0b want %0b", i, if_done_o, (i == 3)); n_bad++; end
      if (i == 1) begin
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin $display("FAIL fetch_issue: got req %0b addr %h we %0b want 1/00000010/0", mem_req_o, mem_addr_o, mem_we_o); n_bad++; end
        n_cmp++; if (if_stall_o !== 1'b1) begin $display("FAIL fetch_stall: got %0b want 1", if_stall_o); n_bad++; end
      end
      if (i == 3) begin
        n_cmp++; if (if_rdata_o !== 32'h13) begin $display("FAIL fetch_rdata: got %h want 00000013", if_rdata_o); n_bad++; end
        n_cmp++; if (if_stall_o !== 1'b0) begin $display("FAIL fetch_stall_done: got %0b want 0", if_stall_o); n_bad++; end
        if_req_i = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    int d_at, i_at, stall_err;
    apply_reset();
    d_at = 0; i_at = 0; stall_err = 0;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
    if_req_i = 1; if_addr_i = 32'h40;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_i); #1;
      if (if_req_i && !if_done_o && !if_stall_o) stall_err++;
      if (d_done_o) begin d_at = i; d_req_i = 0; d_we_i = 0; end
      if (if_done_o) begin
        i_at = i;
        n_cmp++; if (if_rdata_o !== 32'h43) begin $display("FAIL simul_if_rdata: got %h want 00000043", if_rdata_o); n_bad++; end
        if_req_i = 0;
      end
    end
    n_cmp++; if (d_at != 2 || i_at != 5) begin $display("FAIL simul_order: got d@%0d if@%0d want d@2 if@5", d_at, i_at); n_bad++; end
    n_cmp++; if (stall_err != 0) begin $display("FAIL simul_if_stall: got %0d low cycles want 0", stall_err); n_bad++; end
    n_cmp++; if (n_log != 2) begin $display("FAIL simul_count: got %0d accesses want 2", n_log); n_bad++; end
    n_cmp++; if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h100 || log_wdata[0] !== 32'hDEAD_BEEF) begin $display("FAIL simul_store: got we %0b addr %h data %h want 1/00000100/deadbeef", log_we[0], log_addr[0], log_wdata[0]); n_bad++; end
    n_cmp++; if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h40) begin $display("FAIL simul_fetch: got we %0b addr %h want 0/00000040", log_we[1], log_addr[1]); n_bad++; end
  endtask

  task automatic test_starvation();
    int i_at, d_before, lead;
    apply_reset();
    i_at = 0; d_before = 0; lead = 0;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200; if_req_i = 1; if_addr_i = 32'h80;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk_i); #1;
      if (d_done_o && i_at == 0) d_before++;
      if (if_done_o) begin i_at = i; if_req_i = 0; end
    end
    d_req_i = 0;
    for (int k = 0; k < n_log; k++) begin
      if (log_addr[k] !== 32'h200) break;
      lead++;
    end
    n_cmp++; if (lead != 4) begin $display("FAIL starve_data_grants: got %0d want 4", lead); n_bad++; end
    n_cmp++; if (d_before != 4) begin $display("FAIL starve_d_done: got %0d want 4", d_before); n_bad++; end
    n_cmp++; if (log_addr[4] !== 32'h80 || log_we[4] !== 1'b0) begin $display("FAIL starve_fetch_grant: got addr %h we %0b want 00000080/0", log_addr[4], log_we[4]); n_bad++; end
    n_cmp++; if (i_at != 14) begin $display("FAIL starve_if_done_cycle: got %0d want 14", i_at); n_bad++; end
    n_cmp++; if (log_addr[5] !== 32'h200) begin $display("FAIL starve_data_resume: got %h want 00000200", log_addr[5]); n_bad++; end
  endtask

  task automatic test_flush();
    int n_done, first_at;
    logic [31:0] first_rdata;
    apply_reset();
    n_done = 0; first_at = 0; first_rdata = '0;
    lat = 3; if_addr_i = 32'h300; if_req_i = 1;
    @(posedge clk_i); #1;
    if_flush_i = 1; if_addr_i = 32'h340;
    @(posedge clk_i); #1;
    if_flush_i = 0;
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin $display("FAIL flush_access_runs: got req %0b addr %h want 1/00000300", mem_req_o, mem_addr_o); n_bad++; end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_i); #1;
      if (if_done_o) begin
        n_done++;
        if (first_at == 0) begin first_at = i; first_rdata = if_rdata_o; end
        if_req_i = 0;
      end
    end
    n_cmp++; if (n_done != 1 || first_at != 6) begin $display("FAIL flush_done: got %0d pulses first@%0d want 1 @6", n_done, first_at); n_bad++; end
    n_cmp++; if (first_rdata !== 32'h343) begin $display("FAIL flush_new_pc_rdata: got %h want 00000343", first_rdata); n_bad++; end
    n_cmp++; if (log_addr[0] !== 32'h300 || log_addr[1] !== 32'h340) begin $display("FAIL flush_addrs: got %h,%h want 00000300,00000340", log_addr[0], log_addr[1]); n_bad++; end
    // flush arriving on the completion cycle
    apply_reset();
    lat = 1; if_addr_i = 32'h600; if_req_i = 1;
    repeat (2) @(posedge clk_i);
    #1 if_flush_i = 1;
    #1;
    n_cmp++; if (if_done_o !== 1'b0) begin $display("FAIL flush_in_done: got %0b want 0", if_done_o); n_bad++; end
    @(posedge clk_i); #1;
    if_flush_i = 0; if_req_i = 0;
    n_cmp++; if (if_done_o !== 1'b0) begin $display("FAIL flush_after_done: got %0b want 0", if_done_o); n_bad++; end
  endtask

  task automatic test_watchdog();
    int d_seen;
    apply_reset();
    d_seen = 0;
    no_ack = 1; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk_i); #1;
      if (d_done_o) d_seen++;
      n_cmp++; if (mem_req_o !== (i <= 8)) begin $display("FAIL wd_mem_req_c%0d: got %0b want %0b", i, mem_req_o, (i <= 8)); n_bad++; end
      n_cmp++; if (timeout_o !== (i == 9)) begin $display("FAIL wd_timeout_c%0d: got %0b want %0b", i, timeout_o, (i == 9)); n_bad++; end
    end
    @(posedge clk_i); #1;
    if (d_done_o) d_seen++;
    n_cmp++; if (mem_req_o !== 1'b1 || timeout_o !== 1'b1 || d_stall_o !== 1'b1) begin $display("FAIL wd_rearb: got req %0b timeout %0b stall %0b want 1/1/1", mem_req_o, timeout_o, d_stall_o); n_bad++; end
    n_cmp++; if (d_seen != 0) begin $display("FAIL wd_no_done: got %0d pulses want 0", d_seen); n_bad++; end
    // reset in the middle of an access
    rst_i = 1;
    @(posedge clk_i); #1;
    n_cmp++; if (mem_req_o !== 1'b0 || timeout_o !== 1'b0 || d_done_o !== 1'b0) begin $display("FAIL wd_mid_reset: got req %0b timeout %0b done %0b want 0/0/0", mem_req_o, timeout_o, d_done_o); n_bad++; end
    d_req_i = 0; no_ack = 0;
    rst_i = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
